// File: rtl/ref_sample_buffer.sv
// Reference-sample store for intra prediction: fills top/left arrays from an
// HEVC substitution-order scan, backfills the leading unavailable run, serves registered reads.
module ref_sample_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_LOG2   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [2:0]            log2_size,
    input  logic                  ld_valid,
    input  logic                  ld_avail,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] address_RAM,
    input  logic                  en_top,
    input  logic                  en_left,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic                  top_valid,
    output logic                  left_valid
);
    localparam int DEPTH = 2 * (1 << MAX_LOG2) + 1;
    localparam int IW    = $clog2(DEPTH);
    localparam int PW    = MAX_LOG2 + 3;
    localparam logic [DATA_WIDTH-1:0] MID_LEVEL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BACKFILL, S_READY} state_t;

    state_t                state_q;
    logic [2:0]            lg_q;
    logic [PW-1:0]         p_q;
    logic [PW-1:0]         k_q;
    logic [PW-1:0]         k_d;
    logic                  seen_q;
    logic [DATA_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] fill_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] top_data_q;
    logic [DATA_WIDTH-1:0] left_data_q;
    logic                  top_valid_q;
    logic                  left_valid_q;

    logic [DATA_WIDTH-1:0] top_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] left_mem [DEPTH];

    logic [2:0]            lg_in;
    logic [PW-1:0]         two_n;
    logic [PW-1:0]         four_n;
    logic                  accept;
    logic                  wr_en;
    logic [PW-1:0]         wr_pos;
    logic [DATA_WIDTH-1:0] wr_val;
    logic                  top_we;
    logic                  left_we;
    logic [IW-1:0]         top_idx;
    logic [IW-1:0]         left_idx;
    logic [31:0]           addr_w;
    logic [IW-1:0]         rd_idx;

    always_comb begin
        if (log2_size < 3'd2) begin
            lg_in = 3'd2;
        end else if (32'(log2_size) > MAX_LOG2) begin
            lg_in = 3'(MAX_LOG2);
        end else begin
            lg_in = log2_size;
        end
        two_n  = PW'(1) << (lg_q + 3'd1);
        four_n = PW'(1) << (lg_q + 3'd2);
        accept = (state_q == S_LOAD) && ld_valid && !load_start;
        k_d    = k_q;
        if (accept && !ld_avail && !seen_q) begin
            k_d = k_q + PW'(1);
        end
    end

    // Substitution write port; leading unavailable samples are skipped and written later in BACKFILL.
    always_comb begin
        wr_en  = 1'b0;
        wr_pos = p_q;
        wr_val = ld_data;
        if (accept) begin
            if (ld_avail) begin
                wr_en = 1'b1;
            end else if (seen_q) begin
                wr_en  = 1'b1;
                wr_val = last_q;
            end
        end else if (state_q == S_BACKFILL && !load_start) begin
            wr_en  = 1'b1;
            wr_val = fill_q;
        end

        top_we   = 1'b0;
        left_we  = 1'b0;
        top_idx  = '0;
        left_idx = '0;
        if (wr_pos < two_n) begin
            left_we  = wr_en;
            left_idx = IW'(two_n - wr_pos);
        end else if (wr_pos == two_n) begin
            top_we  = wr_en;
            left_we = wr_en;
        end else begin
            top_we  = wr_en;
            top_idx = IW'(wr_pos - two_n);
        end

        addr_w = 32'(address_RAM);
        rd_idx = (addr_w > 32'(two_n)) ? IW'(two_n) : IW'(addr_w);
    end

    always_ff @(posedge clk) begin
        if (top_we) begin
            top_mem[top_idx] <= wr_val;
        end
        if (left_we) begin
            left_mem[left_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lg_q         <= 3'd2;
            p_q          <= '0;
            k_q          <= '0;
            seen_q       <= 1'b0;
            last_q       <= '0;
            fill_q       <= '0;
            ready_q      <= 1'b0;
            top_data_q   <= '0;
            left_data_q  <= '0;
            top_valid_q  <= 1'b0;
            left_valid_q <= 1'b0;
        end else begin
            top_valid_q  <= 1'b0;
            left_valid_q <= 1'b0;
            // Reads use the pre-edge ready, so a read alongside load_start is still served.
            if (ready_q && en_top) begin
                top_data_q  <= top_mem[rd_idx];
                top_valid_q <= 1'b1;
            end
            if (ready_q && en_left) begin
                left_data_q  <= left_mem[rd_idx];
                left_valid_q <= 1'b1;
            end

            if (load_start) begin
                state_q <= S_LOAD;
                lg_q    <= lg_in;
                p_q     <= '0;
                k_q     <= '0;
                seen_q  <= 1'b0;
                fill_q  <= MID_LEVEL;
                ready_q <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (accept) begin
                            if (ld_avail) begin
                                last_q <= ld_data;
                                seen_q <= 1'b1;
                                if (!seen_q) begin
                                    fill_q <= ld_data;
                                end
                            end
                            k_q <= k_d;
                            if (p_q == four_n) begin
                                p_q     <= '0;
                                state_q <= (k_d != '0) ? S_BACKFILL : S_READY;
                            end else begin
                                p_q <= p_q + PW'(1);
                            end
                        end
                    end
                    S_BACKFILL: begin
                        if (p_q == k_q - PW'(1)) begin
                            state_q <= S_READY;
                        end else begin
                            p_q <= p_q + PW'(1);
                        end
                    end
                    S_READY: ready_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign ready      = ready_q;
    assign top_data   = top_data_q;
    assign left_data  = left_data_q;
    assign top_valid  = top_valid_q;
    assign left_valid = left_valid_q;
endmodule

// File: tb/tb_ref_sample_buffer.sv
// Self-checking bench for ref_sample_buffer: directed scan scenarios, a vector table,
// and randomized fills checked against a scan-level substitution model.
module tb_ref_sample_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic [2:0] log2_size;
    logic       ld_valid;
    logic       ld_avail;
    logic [7:0] ld_data;
    logic       ready;
    logic [7:0] address_RAM;
    logic       en_top;
    logic       en_left;
    logic [7:0] top_data;
    logic [7:0] left_data;
    logic       top_valid;
    logic       left_valid;

    ref_sample_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MAX_LOG2(5)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .log2_size(log2_size),
        .ld_valid(ld_valid), .ld_avail(ld_avail), .ld_data(ld_data), .ready(ready),
        .address_RAM(address_RAM), .en_top(en_top), .en_left(en_left),
        .top_data(top_data), .left_data(left_data),
        .top_valid(top_valid), .left_valid(left_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int sc_av [140];
    int sc_dat[140];
    int exp_top [65];
    int exp_left[65];
    int exp_k;
    int cur_n2 = 8;
    int t_last = 0;
    int t_ready = -1;

    typedef struct {
        bit et;
        bit el;
        int addr;
        int xt;
        int xl;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic int eff_lg(input int lg);
        return (lg < 2) ? 2 : (lg > 5) ? 5 : lg;
    endfunction

    // Expected array contents straight from the scan: each position takes its own sample,
    // else the latest earlier available one, else the first available, else mid-level.
    task automatic build_model(input int lg);
        int total, first, last, v;
        cur_n2 = 2 * (1 << eff_lg(lg));
        total  = 2 * cur_n2 + 1;
        first  = -1;
        for (int p = 0; p < total; p++)
            if (first < 0 && sc_av[p] != 0) first = p;
        last  = (first < 0) ? 128 : sc_dat[first];
        exp_k = (first < 0) ? total : first;
        for (int p = 0; p < total; p++) begin
            if (sc_av[p] != 0) last = sc_dat[p];
            v = last;
            if (p < cur_n2) exp_left[cur_n2 - p] = v;
            else if (p == cur_n2) begin exp_top[0] = v; exp_left[0] = v; end
            else exp_top[p - cur_n2] = v;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ready && t_ready < 0) t_ready = cyc;
    endtask

    task automatic start_load(input int lg);
        t_ready    = -1;
        load_start = 1'b1;
        log2_size  = 3'(lg);
        step();
        load_start = 1'b0;
    endtask

    task automatic feed(input int nsamp, input int gap_pct, input bit rd_during, output int bad);
        bad     = 0;
        en_top  = rd_during;
        en_left = rd_during;
        for (int i = 0; i < nsamp; i++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                ld_valid = 1'b0;
                step();
                if (top_valid || left_valid) bad++;
            end
            ld_valid = 1'b1;
            ld_avail = (sc_av[i] != 0);
            ld_data  = 8'(sc_dat[i]);
            step();
            if (top_valid || left_valid) bad++;
            if (i == 2 * cur_n2) t_last = cyc;
        end
        ld_valid = 1'b0;
        en_top   = 1'b0;
        en_left  = 1'b0;
    endtask

    task automatic wait_ready(output int lat);
        for (int c = 0; c < 400 && t_ready < 0; c++) step();
        lat = (t_ready < 0) ? -1 : t_ready - t_last;
    endtask

    task automatic rd(input bit et, input bit el, input int addr, input int xt, input int xl,
                      input string tag);
        en_top      = et;
        en_left     = el;
        address_RAM = 8'(addr);
        step();
        en_top  = 1'b0;
        en_left = 1'b0;
        check({tag, " top_valid"}, int'(top_valid), int'(et));
        check({tag, " left_valid"}, int'(left_valid), int'(el));
        check({tag, " top_data"}, int'(top_data), xt);
        check({tag, " left_data"}, int'(left_data), xl);
    endtask

    task automatic rd_all(input string tag);
        int idx;
        for (int a = 0; a <= cur_n2 + 2; a++) begin
            idx = (a > cur_n2) ? cur_n2 : a;
            rd(1'b1, 1'b1, a, exp_top[idx], exp_left[idx], $sformatf("%s a%0d", tag, a));
        end
        rd(1'b1, 1'b1, 255, exp_top[cur_n2], exp_left[cur_n2], {tag, " a255"});
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " ready"}, int'(ready), 0);
        check({tag, " top_valid"}, int'(top_valid), 0);
        check({tag, " left_valid"}, int'(left_valid), 0);
        check({tag, " top_data"}, int'(top_data), 0);
        check({tag, " left_data"}, int'(left_data), 0);
    endtask

    task automatic scan_ramp(input int total, input int base);
        for (int p = 0; p < total; p++) begin
            sc_av[p]  = 1;
            sc_dat[p] = base + p;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bad, bad2, lg, total, mode, lead, extra;

        rst = 1'b1; load_start = 1'b0; log2_size = 3'd2; ld_valid = 1'b0; ld_avail = 1'b0;
        ld_data = '0; address_RAM = '0; en_top = 1'b0; en_left = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        step();

        // All available, N=4
        scan_ramp(17, 'h10);
        build_model(2);
        start_load(2);
        feed(17, 0, 1'b0, bad);
        wait_ready(lat);
        check("s1 ready latency", lat, 1);
        tbl[0] = '{1'b1, 1'b0, 3,   'h1B, 'h00};
        tbl[1] = '{1'b0, 1'b1, 8,   'h1B, 'h10};
        tbl[2] = '{1'b1, 1'b1, 0,   'h18, 'h18};
        tbl[3] = '{1'b0, 1'b0, 5,   'h18, 'h18};
        tbl[4] = '{1'b1, 1'b1, 2,   'h1A, 'h16};
        tbl[5] = '{1'b1, 1'b1, 200, 'h20, 'h10};
        tbl[6] = '{1'b1, 1'b0, 9,   'h20, 'h10};
        tbl[7] = '{1'b0, 1'b1, 1,   'h20, 'h17};
        for (int i = 0; i < 8; i++)
            rd(tbl[i].et, tbl[i].el, tbl[i].addr, tbl[i].xt, tbl[i].xl, $sformatf("tbl%0d", i));

        // Restart with a same-edge read, abandoned partial load, then full reload
        en_top = 1'b1; address_RAM = 8'd3; load_start = 1'b1; log2_size = 3'd2;
        step();
        en_top = 1'b0; load_start = 1'b0;
        check("restart read valid", int'(top_valid), 1);
        check("restart read data", int'(top_data), 'h1B);
        check("restart ready low", int'(ready), 0);
        scan_ramp(17, 'hA0);
        feed(5, 0, 1'b1, bad);
        scan_ramp(17, 'h60);
        sc_av[0] = 0; sc_av[1] = 0;
        build_model(2);
        start_load(2);
        feed(17, 0, 1'b1, bad2);
        check("no valid during LOAD", bad + bad2, 0);
        wait_ready(lat);
        check("reload ready latency", lat, 3);
        rd_all("reload");

        // Leading gap, N=4
        scan_ramp(17, 'h10);
        sc_av[0] = 0; sc_av[1] = 0; sc_av[2] = 0; sc_dat[3] = 'h55;
        build_model(2);
        start_load(2);
        feed(17, 0, 1'b0, bad);
        wait_ready(lat);
        check("lead ready latency", lat, 4);
        rd(1'b0, 1'b1, 8, int'(top_data), 'h55, "lead left8");
        rd(1'b0, 1'b1, 7, int'(top_data), 'h55, "lead left7");
        rd(1'b0, 1'b1, 6, int'(top_data), 'h55, "lead left6");
        rd_all("lead");

        // Middle gap, N=4
        scan_ramp(17, 'h10);
        sc_dat[9] = 'h33; sc_av[10] = 0; sc_av[11] = 0; sc_dat[12] = 'h40;
        build_model(2);
        start_load(2);
        feed(17, 0, 1'b0, bad);
        wait_ready(lat);
        check("mid ready latency", lat, 1);
        rd(1'b1, 1'b0, 1, 'h33, int'(left_data), "mid top1");
        rd(1'b1, 1'b0, 2, 'h33, int'(left_data), "mid top2");
        rd(1'b1, 1'b0, 3, 'h33, int'(left_data), "mid top3");
        rd(1'b1, 1'b0, 4, 'h40, int'(left_data), "mid top4");
        rd_all("mid");

        // All unavailable, N=8
        for (int p = 0; p < 33; p++) begin sc_av[p] = 0; sc_dat[p] = p * 7; end
        build_model(3);
        start_load(3);
        feed(33, 0, 1'b0, bad);
        wait_ready(lat);
        check("unavail ready latency", lat, 34);
        rd_all("unavail");
        rd(1'b1, 1'b1, 200, 'h80, 'h80, "unavail a200");

        // Async reset mid-BACKFILL, then the first scenario again
        start_load(3);
        feed(33, 0, 1'b0, bad);
        repeat (5) step();
        #3 rst = 1'b1;
        #1 check_zero_outputs("rst backfill");
        #2 rst = 1'b0;
        step();
        scan_ramp(17, 'h10);
        build_model(2);
        start_load(2);
        feed(17, 0, 1'b0, bad);
        wait_ready(lat);
        check("post-rst ready latency", lat, 1);
        rd(1'b1, 1'b1, 3, 'h1B, 'h15, "post-rst a3");
        rd(1'b0, 1'b1, 8, 'h1B, 'h10, "post-rst left8");
        #3 rst = 1'b1;
        #1 check("rst in READY ready", int'(ready), 0);
        check("rst in READY top_data", int'(top_data), 0);
        #2 rst = 1'b0;
        step();

        // Randomized fills against the scan model
        for (int it = 0; it < 10; it++) begin
            lg    = int'($urandom_range(7));
            total = 4 * (1 << eff_lg(lg)) + 1;
            mode  = int'($urandom_range(3));
            lead  = int'($urandom_range(total - 1));
            extra = int'($urandom_range(3));
            for (int p = 0; p < total + extra; p++) begin
                sc_dat[p] = int'($urandom_range(255));
                if (mode == 0) sc_av[p] = 1;
                else if (mode == 1) sc_av[p] = 0;
                else sc_av[p] = (p >= lead && $urandom_range(99) < 70) ? 1 : 0;
            end
            build_model(lg);
            start_load(lg);
            feed(total + extra, 20, 1'b0, bad);
            wait_ready(lat);
            check($sformatf("rand%0d ready latency", it), lat, 1 + exp_k);
            rd_all($sformatf("rand%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
